// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shifts and shift-add multiply.
// Results and Zero/Sign/Carry flags are registered and update together with a one-cycle Done pulse.
module seq_alu #(
   parameter int W   = 8,
   parameter int Ops = 3
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           Start,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic [Ops-1:0] OP,
   output logic           Busy,
   output logic           Done,
   output logic [W-1:0]   Out,
   output logic           Zero,
   output logic           Sign,
   output logic           Carry,
   output logic [1:0]     state_dbg
);

   // Handshake: Start is the request and !Busy the ready; an op is accepted on a
   // rising edge where Start=1 and Busy=0, and its operands are captured there.

   localparam int CW = (W > 2) ? $clog2(W) : 1;

   localparam logic [Ops-1:0] OP_ADD = Ops'(0);
   localparam logic [Ops-1:0] OP_SHR = Ops'(1);
   localparam logic [Ops-1:0] OP_SHL = Ops'(2);
   localparam logic [Ops-1:0] OP_XOR = Ops'(3);
   localparam logic [Ops-1:0] OP_SUB = Ops'(4);
   localparam logic [Ops-1:0] OP_AND = Ops'(5);
   localparam logic [Ops-1:0] OP_OR  = Ops'(6);
   localparam logic [Ops-1:0] OP_MUL = Ops'(7);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_MUL   = 2'd2
   } state_t;

   state_t         state;
   logic [Ops-1:0] op_q;
   logic [W-1:0]   work;
   logic [W-1:0]   acc;
   logic [W-1:0]   mcand;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  cnt;

   logic           accept;
   logic [W:0]     sum;
   logic           is_shift;
   logic           big_shift;
   logic           long_shift;
   logic [W-1:0]   a_step;
   logic [W-1:0]   w_step;
   logic [W-1:0]   acc_next;
   logic [W-1:0]   res;
   logic           res_c;
   logic           fin;
   logic [W-1:0]   fin_res;
   logic           fin_c;

   assign state_dbg = state;

   always_comb begin
      accept     = Start && !Busy;
      sum        = {1'b0, A} + {1'b0, B};
      is_shift   = (OP == OP_SHR) || (OP == OP_SHL);
      big_shift  = ({1'b0, B} >= (W+1)'(W));
      // Shifts of 1 finish at the accept edge; longer in-range shifts iterate.
      long_shift = is_shift && !big_shift && (B > W'(1));
      a_step     = (OP == OP_SHL) ? (A << 1) : (A >> 1);
      w_step     = (op_q == OP_SHL) ? (work << 1) : (work >> 1);
      acc_next   = acc + (mplier[0] ? mcand : '0);

      res   = '0;
      res_c = 1'b0;
      case (OP)
         OP_ADD: begin
            res   = sum[W-1:0];
            res_c = sum[W];
         end
         OP_SUB: begin
            res   = A - B;
            res_c = (A < B);
         end
         OP_AND: res = A & B;
         OP_OR:  res = A | B;
         OP_XOR: res = {{(W-1){1'b0}}, ^A};
         OP_SHR, OP_SHL: begin
            if (B == '0)     res = A;
            else if (big_shift) res = '0;
            else             res = a_step;
         end
         default: res = '0;
      endcase

      fin     = 1'b0;
      fin_res = res;
      fin_c   = res_c;
      case (state)
         S_IDLE:  fin = accept && (OP != OP_MUL) && !long_shift;
         S_SHIFT: begin
            fin     = (cnt == CW'(1));
            fin_res = w_step;
            fin_c   = 1'b0;
         end
         S_MUL: begin
            fin     = (cnt == CW'(1));
            fin_res = acc_next;
            fin_c   = 1'b0;
         end
         default: fin = 1'b0;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state  <= S_IDLE;
         Busy   <= 1'b0;
         Done   <= 1'b0;
         Out    <= '0;
         Zero   <= 1'b0;
         Sign   <= 1'b0;
         Carry  <= 1'b0;
         op_q   <= '0;
         work   <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else begin
         Done <= 1'b0;
         if (fin) begin
            Out   <= fin_res;
            Zero  <= (fin_res == '0);
            Sign  <= fin_res[W-1];
            Carry <= fin_c;
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept) begin
                     op_q <= OP;
                     // The first step is taken at the accept edge so Done lands B (or W) cycles later.
                     if (OP == OP_MUL) begin
                        state  <= S_MUL;
                        Busy   <= 1'b1;
                        acc    <= B[0] ? A : '0;
                        mcand  <= A << 1;
                        mplier <= B >> 1;
                        cnt    <= CW'(W - 1);
                     end else if (long_shift) begin
                        state <= S_SHIFT;
                        Busy  <= 1'b1;
                        work  <= a_step;
                        cnt   <= CW'(B - W'(1));
                     end
                  end
               end
               S_SHIFT: begin
                  work <= w_step;
                  cnt  <= cnt - CW'(1);
               end
               S_MUL: begin
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt - CW'(1);
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (W=8): results, flags, latencies, busy behaviour and reset abort.
module tb_seq_alu;

   logic       Clk;
   logic       Reset_n;
   logic       Start;
   logic [7:0] A;
   logic [7:0] B;
   logic [2:0] OP;
   logic       Busy;
   logic       Done;
   logic [7:0] Out;
   logic       Zero;
   logic       Sign;
   logic       Carry;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;

   seq_alu #(.W(8), .Ops(3)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .A(A), .B(B), .OP(OP),
      .Busy(Busy), .Done(Done), .Out(Out), .Zero(Zero), .Sign(Sign), .Carry(Carry),
      .state_dbg(state_dbg)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Drives one request; returns 1 ns after the accept edge.
   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge Clk);
      Start = 1'b1; OP = op; A = a; B = b;
      @(posedge Clk); #1;
      Start = 1'b0;
   endtask

   // lat counts cycles after the accept edge until Done is seen (1 = next cycle).
   task automatic wait_done(output int lat, output int busy_cyc);
      lat = 1;
      busy_cyc = 0;
      while (Done !== 1'b1 && lat < 40) begin
         if (Busy === 1'b1) busy_cyc++;
         @(posedge Clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; Start = 1'b0; A = '0; B = '0; OP = '0;
      repeat (3) @(posedge Clk);
      #1;
      checks++; if ({Busy, Done, Zero, Sign, Carry} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b want 00000", {Busy, Done, Zero, Sign, Carry}); end
      checks++; if (Out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", Out); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
      @(negedge Clk); Reset_n = 1'b1;
   endtask

   task automatic test_add_sub();
      int lat, bc;
      issue(3'b000, 8'hF0, 8'h20);
      wait_done(lat, bc);
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_lat got %0d want 1", lat); end
      checks++; if (Out !== 8'h10) begin errors++; $display("FAIL add_out got %h want 10", Out); end
      checks++; if ({Zero, Sign, Carry} !== 3'b001) begin errors++; $display("FAIL add_flags got %b want 001", {Zero, Sign, Carry}); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL add_busy got %b want 0", Busy); end
      @(posedge Clk); #1;
      checks++; if (Done !== 1'b0 || Out !== 8'h10) begin errors++; $display("FAIL add_hold got done=%b out=%h want 0/10", Done, Out); end
      issue(3'b100, 8'd5, 8'd5);
      wait_done(lat, bc);
      checks++; if ({Out, Zero, Sign, Carry} !== {8'h00, 3'b100}) begin errors++; $display("FAIL sub_eq got %h/%b want 00/100", Out, {Zero, Sign, Carry}); end
      issue(3'b100, 8'd3, 8'd5);
      wait_done(lat, bc);
      checks++; if ({Out, Zero, Sign, Carry} !== {8'hFE, 3'b011}) begin errors++; $display("FAIL sub_neg got %h/%b want fe/011", Out, {Zero, Sign, Carry}); end
   endtask

   task automatic test_logic();
      int lat, bc;
      issue(3'b101, 8'hCA, 8'h3F);
      wait_done(lat, bc);
      checks++; if ({Out, Zero, Sign, Carry} !== {8'h0A, 3'b000}) begin errors++; $display("FAIL and got %h/%b want 0a/000", Out, {Zero, Sign, Carry}); end
      issue(3'b110, 8'h81, 8'h14);
      wait_done(lat, bc);
      checks++; if ({Out, Zero, Sign, Carry} !== {8'h95, 3'b010}) begin errors++; $display("FAIL or got %h/%b want 95/010", Out, {Zero, Sign, Carry}); end
   endtask

   task automatic test_shift();
      int lat, bc;
      issue(3'b010, 8'h01, 8'd3);
      checks++; if (state_dbg !== 2'd1 || Busy !== 1'b1) begin errors++; $display("FAIL shl_enter got st=%0d busy=%b want 1/1", state_dbg, Busy); end
      wait_done(lat, bc);
      checks++; if (lat !== 3 || bc !== 2) begin errors++; $display("FAIL shl_timing got lat=%0d busy=%0d want 3/2", lat, bc); end
      checks++; if ({Out, Zero, Sign, Carry} !== {8'h08, 3'b000}) begin errors++; $display("FAIL shl_out got %h/%b want 08/000", Out, {Zero, Sign, Carry}); end
      issue(3'b001, 8'h80, 8'd9);
      wait_done(lat, bc);
      checks++; if (lat !== 1 || Out !== 8'h00 || Zero !== 1'b1) begin errors++; $display("FAIL shr_big got lat=%0d out=%h z=%b want 1/00/1", lat, Out, Zero); end
      issue(3'b001, 8'h80, 8'd7);
      wait_done(lat, bc);
      checks++; if (lat !== 7 || Out !== 8'h01) begin errors++; $display("FAIL shr_7 got lat=%0d out=%h want 7/01", lat, Out); end
      issue(3'b010, 8'hA5, 8'd0);
      wait_done(lat, bc);
      checks++; if (lat !== 1 || Out !== 8'hA5 || Sign !== 1'b1) begin errors++; $display("FAIL shl_0 got lat=%0d out=%h s=%b want 1/a5/1", lat, Out, Sign); end
      issue(3'b010, 8'h41, 8'd1);
      wait_done(lat, bc);
      checks++; if (lat !== 1 || Out !== 8'h82) begin errors++; $display("FAIL shl_1 got lat=%0d out=%h want 1/82", lat, Out); end
   endtask

   task automatic test_mul();
      int lat;
      issue(3'b111, 8'd13, 8'd11);
      checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL mul_enter got %0d want 2", state_dbg); end
      // A competing request while busy must be ignored.
      Start = 1'b1; OP = 3'b000; A = 8'd1; B = 8'd1;
      @(posedge Clk); #1;
      Start = 1'b0;
      lat = 2;
      checks++; if (Done !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL mul_ignore got done=%b busy=%b want 0/1", Done, Busy); end
      while (Done !== 1'b1 && lat < 40) begin
         @(posedge Clk); #1;
         lat++;
      end
      checks++; if (lat !== 8) begin errors++; $display("FAIL mul_lat got %0d want 8", lat); end
      checks++; if ({Out, Zero, Sign, Carry} !== {8'h8F, 3'b010}) begin errors++; $display("FAIL mul_out got %h/%b want 8f/010", Out, {Zero, Sign, Carry}); end
      issue(3'b111, 8'd20, 8'd16);
      wait_done(lat, lat);
      checks++; if (Out !== 8'h40) begin errors++; $display("FAIL mul_wrap got %h want 40", Out); end
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      issue(3'b011, 8'b1011_0000, 8'h00);
      wait_done(lat, bc);
      checks++; if (lat !== 1 || Out !== 8'h01) begin errors++; $display("FAIL xor_red got lat=%0d out=%h want 1/01", lat, Out); end
      Start = 1'b1; OP = 3'b000; A = 8'h7F; B = 8'h01;
      @(posedge Clk); #1;
      Start = 1'b0;
      checks++; if (Done !== 1'b1 || Out !== 8'h80) begin errors++; $display("FAIL b2b_add got done=%b out=%h want 1/80", Done, Out); end
      checks++; if ({Zero, Sign, Carry} !== 3'b010) begin errors++; $display("FAIL b2b_flags got %b want 010", {Zero, Sign, Carry}); end
   endtask

   task automatic test_reset_abort();
      int seen;
      issue(3'b111, 8'd13, 8'd11);
      repeat (3) begin @(posedge Clk); #1; end
      Reset_n = 1'b0;
      #1;
      checks++; if ({Busy, Done, Out, Zero, Sign, Carry} !== 12'h000) begin errors++; $display("FAIL abort_out got busy=%b done=%b out=%h flags=%b want all 0", Busy, Done, Out, {Zero, Sign, Carry}); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL abort_state got %0d want 0", state_dbg); end
      @(negedge Clk); Reset_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge Clk); #1;
         if (Done === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_nodone got %0d want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic();
      test_shift();
      test_mul();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Clocked, parametrised ALU for the CPU datapath.
- Accepts one operation per Start handshake and returns a registered result with Zero/Sign/Carry flags.
- Single-cycle ops complete in 1 cycle; shifts and multiply run iteratively over several cycles while Busy is high.
- Sits between register-file read and writeback; the controller stalls on Busy and captures Out on Done.

Parameters:
- W, 8, operand/result width in bits (W >= 2).
- Ops, 3, opcode width in bits (fixed encoding below needs 3).

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  request; accepted only when Busy=0.
- A  in  W  operand A, sampled at accept.
- B  in  W  operand B / shift amount (unsigned), sampled at accept.
- OP  in  Ops  opcode, sampled at accept.
- Busy  out  1  operation in progress; Start ignored while high.
- Done  out  1  one-cycle pulse when Out/flags update.
- Out  out  W  registered result, held until the next Done.
- Zero  out  1  Out==0, registered with Out.
- Sign  out  1  Out[W-1], registered with Out.
- Carry  out  1  ADD carry-out / SUB borrow (A<B); 0 for other ops.

Behaviour:
- Reset (async, Reset_n=0): state IDLE, Busy=0, Done=0, Out=0, Zero=0, Sign=0, Carry=0, internal counters and operand registers 0.
- Accept: Start=1 and Busy=0 at a rising edge latches A, B and OP.
- Start while Busy=1 is ignored; the latched operands do not change.
- Opcodes:
  - 000 ADD: A+B mod 2^W.
  - 001 SHR: logical A>>B.
  - 010 SHL: A<<B.
  - 011 XOR-reduce: Out = {W-1 zeros, ^A}.
  - 100 SUB: A-B mod 2^W.
  - 101 AND.
  - 110 OR.
  - 111 MUL: low W bits of A*B, unsigned.
- States: IDLE, SHIFT, MUL.
  - IDLE + accept of a single-cycle op (ADD/SUB/AND/OR/XOR), or a shift with B=0 or B>=W: result is computed and registered at the accept edge. Done=1 and Busy=0 in the following cycle. Latency 1.
    - Shift with B=0 gives Out=A.
    - Shift with B>=W gives Out=0.
  - IDLE + shift with 1<=B<W: go to SHIFT, Busy=1, working register = A, count = B.
    - Each cycle: shift by 1 and decrement count.
    - When count reaches 0: register the result, pulse Done, return to IDLE.
    - Done is asserted exactly B cycles after the accept edge.
  - IDLE + MUL: go to MUL, Busy=1, accumulator = 0.
    - Shift-add one bit of B per cycle, LSB first, for W cycles.
    - Done is asserted W cycles after accept; the accumulator wraps mod 2^W.
- Busy is high from the cycle after accept until the cycle Done is asserted; it is low in that Done cycle.
- Back-to-back: Start may be accepted in the same cycle Done is high (Busy=0). Each op therefore issues every (latency) cycles, and single-cycle ops give one result per cycle.
- Out, Zero, Sign and Carry change only on the Done update, and all four update together.
- Carry: ADD gives bit W of A+B; SUB gives 1 if A<B unsigned.
- Reset asserted mid-operation aborts immediately to IDLE with the reset values above; no Done is generated for the aborted op.

Test Plan:
- Reset, then Start ADD A=8'hF0 B=8'h20 -> 1 cycle later Done=1, Out=8'h10, Carry=1, Zero=0, Sign=0.
- SUB A=5 B=5 -> Out=0, Zero=1, Carry=0. SUB A=3 B=5 -> Out=8'hFE, Sign=1, Carry=1.
- SHL A=8'h01 B=3 -> Busy=1 for 2 cycles, Done exactly 3 cycles after accept, Out=8'h08. SHR A=8'h80 B=9 -> Done after 1 cycle, Out=0, Zero=1.
- MUL A=13 B=11 -> Done 8 cycles after accept, Out=8'h8F (143). A second Start during Busy is ignored, and the result is unchanged.
- XOR-reduce A=8'b1011_0000 -> Out=1. Then ADD issued in the Done cycle -> accepted, its Done follows 1 cycle later.
- Start MUL, drop Reset_n on cycle 4 -> Busy=0, Out=0, flags 0 immediately. After release, no Done until a new Start.
